tqvp_cordic_host: RTL and testbench

Bus-initiator sequencer that drives the TinyQV peripheral register interface of the CORDIC peripheral on behalf of a streaming client. It accepts one job (mode, direction, A, B, shift) on a valid/ready port and issues the register-write sequence to the peripheral. It then waits for the peripheral interrupt, reads both results back, and returns them on a second valid/ready port. It is the master end of the same address/data_write_n/data_read_n/data_ready protocol the peripheral responds to.

---
 rtl/tqvp_cordic_host.sv | 257 +++++++++++++++++++++++++
 tb/tb_tqvp_cordic_host.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_cordic_host.sv
// tqvp_cordic_host: bus-initiator sequencer for the TinyQV CORDIC peripheral.
// It accepts one job from a streaming client and writes A, B, shift and ctrl
// to the peripheral. It then waits for the done interrupt, with a timeout,
// reads both results back and presents them on a valid/ready result port.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   job_*                      job request (valid/ready), operands and control
//   res_*                      result response (valid/ready), results, timeout flag
//   address, data_out          peripheral register address and write data
//   data_write_n, data_read_n  access strobes (11 idle, 00 8-bit, 01 16-bit)
//   data_in, data_ready        peripheral read data and its valid strobe
//   user_interrupt             peripheral done pulse
//   busy                       high whenever not idle
module tqvp_cordic_host #(
  parameter int unsigned FIXED_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [1:0]             job_mode,
  input  logic                   job_rotating,
  input  logic [FIXED_WIDTH-1:0] job_a,
  input  logic [FIXED_WIDTH-1:0] job_b,
  input  logic [4:0]             job_shift,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FIXED_WIDTH-1:0] res_out1,
  output logic [FIXED_WIDTH-1:0] res_out2,
  output logic                   res_timeout,
  output logic [5:0]             address,
  output logic [31:0]            data_out,
  output logic [1:0]             data_write_n,
  output logic [1:0]             data_read_n,
  input  logic [31:0]            data_in,
  input  logic                   data_ready,
  input  logic                   user_interrupt,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [5:0] ADDR_CTRL = 6'd0;
  localparam logic [5:0] ADDR_A    = 6'd1;
  localparam logic [5:0] ADDR_B    = 6'd2;
  localparam logic [5:0] ADDR_SH   = 6'd3;
  localparam logic [5:0] ADDR_OUT1 = 6'd4;
  localparam logic [5:0] ADDR_OUT2 = 6'd5;

  localparam logic [1:0] ACC_NONE = 2'b11;
  localparam logic [1:0] ACC_8    = 2'b00;
  localparam logic [1:0] ACC_16   = 2'b01;

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_SHIFT,
    WR_CTRL,
    WAIT_DONE,
    RD_OUT1,
    RD_OUT2,
    RESP
  } state_t;

  state_t state, nxt;

  // Captured job fields
  logic [1:0]             mode_q;
  logic                   rot_q;
  logic [FIXED_WIDTH-1:0] a_q;
  logic [FIXED_WIDTH-1:0] b_q;
  logic [4:0]             shift_q;

  // Interrupt wait bookkeeping
  logic [CNT_W-1:0] cnt;
  logic             wait_entry;

  // Next-cycle bus values and datapath controls
  logic [5:0]  addr_d;
  logic [31:0] dout_d;
  logic [1:0]  wn_d;
  logic [1:0]  rn_d;
  logic        cap1;
  logic        cap2;
  logic        tmo;
  logic        accept;

  // Read data above the result width carries nothing for this host
  logic unused_data_hi;
  assign unused_data_hi = ^data_in[31:FIXED_WIDTH];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state, plus bus values for the state being entered so that the
  // registered bus lines up with the state itself
  always_comb begin
    nxt    = state;
    addr_d = 6'd0;
    dout_d = 32'd0;
    wn_d   = ACC_NONE;
    rn_d   = ACC_NONE;
    cap1   = 1'b0;
    cap2   = 1'b0;
    tmo    = 1'b0;
    accept = 1'b0;

    case (state)
      IDLE: begin
        if (job_valid) begin
          accept = 1'b1;
          nxt    = WR_A;
        end
      end
      WR_A:     nxt = WR_B;
      WR_B:     nxt = WR_SHIFT;
      WR_SHIFT: nxt = WR_CTRL;
      WR_CTRL:  nxt = WAIT_DONE;
      WAIT_DONE: begin
        // Interrupt has priority over a coincident timeout
        if (user_interrupt) begin
          nxt = RD_OUT1;
        end else if (!wait_entry && (cnt == CNT_W'(TIMEOUT_CYCLES))) begin
          tmo = 1'b1;
          nxt = RESP;
        end
      end
      RD_OUT1: begin
        if (data_ready) begin
          cap1 = 1'b1;
          nxt  = RD_OUT2;
        end
      end
      RD_OUT2: begin
        if (data_ready) begin
          cap2 = 1'b1;
          nxt  = RESP;
        end
      end
      RESP: begin
        if (res_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    case (nxt)
      WR_A: begin
        // Only reachable from IDLE, where the job is still on the input port
        addr_d = ADDR_A;
        wn_d   = ACC_16;
        dout_d = 32'(job_a);
      end
      WR_B: begin
        addr_d = ADDR_B;
        wn_d   = ACC_16;
        dout_d = 32'(b_q);
      end
      WR_SHIFT: begin
        addr_d = ADDR_SH;
        wn_d   = ACC_8;
        dout_d = 32'(shift_q);
      end
      WR_CTRL: begin
        addr_d = ADDR_CTRL;
        wn_d   = ACC_8;
        dout_d = {28'd0, rot_q, mode_q, 1'b1};
      end
      RD_OUT1: begin
        addr_d = ADDR_OUT1;
        rn_d   = ACC_16;
      end
      RD_OUT2: begin
        addr_d = ADDR_OUT2;
        rn_d   = ACC_16;
      end
      default: ;
    endcase
  end

  // Job capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'd0;
      rot_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= 5'd0;
    end else if (accept) begin
      mode_q  <= job_mode;
      rot_q   <= job_rotating;
      a_q     <= job_a;
      b_q     <= job_b;
      shift_q <= job_shift;
    end
  end

  // Timeout counter: cleared outside WAIT_DONE and in its entry cycle, then
  // counts cycles without an interrupt, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      wait_entry <= 1'b0;
    end else begin
      wait_entry <= (nxt == WAIT_DONE) && (state != WAIT_DONE);
      if ((state != WAIT_DONE) || wait_entry) begin
        cnt <= '0;
      end else if (!user_interrupt && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered bus, handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address      <= 6'd0;
      data_out     <= 32'd0;
      data_write_n <= ACC_NONE;
      data_read_n  <= ACC_NONE;
      job_ready    <= 1'b1;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
    end else begin
      address      <= addr_d;
      data_out     <= dout_d;
      data_write_n <= wn_d;
      data_read_n  <= rn_d;
      job_ready    <= (nxt == IDLE);
      busy         <= (nxt != IDLE);
      res_valid    <= (nxt == RESP);
    end
  end

  // Result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_out1    <= '0;
      res_out2    <= '0;
      res_timeout <= 1'b0;
    end else if (tmo) begin
      res_out1    <= '0;
      res_out2    <= '0;
      res_timeout <= 1'b1;
    end else begin
      if (accept) res_timeout <= 1'b0;
      if (cap1)   res_out1    <= data_in[FIXED_WIDTH-1:0];
      if (cap2)   res_out2    <= data_in[FIXED_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_tqvp_cordic_host.sv
// Directed bench for tqvp_cordic_host. Instance 0 uses the default timeout,
// instance 1 a 15-cycle timeout; sel picks which one gets jobs and is observed.
module tb_tqvp_cordic_host;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sel;
  logic         job_valid;
  logic [1:0]   job_mode;
  logic         job_rotating;
  logic [W-1:0] job_a, job_b;
  logic [4:0]   job_shift;
  logic         res_ready;
  logic [31:0]  data_in;
  logic         data_ready;
  logic         user_interrupt;

  logic [1:0]         jv;
  logic [1:0]         jr, rv, rt, bz;
  logic [1:0][W-1:0]  o1, o2;
  logic [1:0][5:0]    ad;
  logic [1:0][31:0]   dout;
  logic [1:0][1:0]    wn, rn;

  assign jv = {job_valid & sel, job_valid & ~sel};

  tqvp_cordic_host #(.FIXED_WIDTH(W), .TIMEOUT_CYCLES(1023)) dut (
    .clk(clk), .rst(rst),
    .job_valid(jv[0]), .job_ready(jr[0]), .job_mode(job_mode),
    .job_rotating(job_rotating), .job_a(job_a), .job_b(job_b), .job_shift(job_shift),
    .res_valid(rv[0]), .res_ready(res_ready), .res_out1(o1[0]), .res_out2(o2[0]),
    .res_timeout(rt[0]), .address(ad[0]), .data_out(dout[0]),
    .data_write_n(wn[0]), .data_read_n(rn[0]), .data_in(data_in),
    .data_ready(data_ready), .user_interrupt(user_interrupt), .busy(bz[0])
  );

  tqvp_cordic_host #(.FIXED_WIDTH(W), .TIMEOUT_CYCLES(15)) dut_to (
    .clk(clk), .rst(rst),
    .job_valid(jv[1]), .job_ready(jr[1]), .job_mode(job_mode),
    .job_rotating(job_rotating), .job_a(job_a), .job_b(job_b), .job_shift(job_shift),
    .res_valid(rv[1]), .res_ready(res_ready), .res_out1(o1[1]), .res_out2(o2[1]),
    .res_timeout(rt[1]), .address(ad[1]), .data_out(dout[1]),
    .data_write_n(wn[1]), .data_read_n(rn[1]), .data_in(data_in),
    .data_ready(data_ready), .user_interrupt(user_interrupt), .busy(bz[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [5:0] a, input logic [1:0] w,
                         input logic [1:0] r, input logic [31:0] d);
    chk({tag, ".addr"}, 32'(ad[sel]), 32'(a));
    chk({tag, ".wr_n"}, 32'(wn[sel]), 32'(w));
    chk({tag, ".rd_n"}, 32'(rn[sel]), 32'(r));
    chk({tag, ".data"}, dout[sel], d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a job for one accept cycle; returns in T1 (first write cycle)
  task automatic start_job(input logic [1:0] m, input logic rot, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [4:0] s);
    job_mode     = m;
    job_rotating = rot;
    job_a        = a;
    job_b        = b;
    job_shift    = s;
    job_valid    = 1'b1;
    tick();
    job_valid    = 1'b0;
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd_seen;
    sel = 1'b0; job_valid = 1'b0; job_mode = 2'd0; job_rotating = 1'b0;
    job_a = '0; job_b = '0; job_shift = 5'd0; res_ready = 1'b0;
    data_in = 32'd0; data_ready = 1'b0; user_interrupt = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst.job_ready", 32'(jr[0]), 32'd1);
    chk("rst.busy", 32'(bz[0]), 32'd0);
    chk("rst.res_valid", 32'(rv[0]), 32'd0);
    chk("rst.res_timeout", 32'(rt[0]), 32'd0);
    chk_bus("rst", 6'd0, 2'b11, 2'b11, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Write sequence and normal completion on instance 0
    sel = 1'b0;
    start_job(2'd0, 1'b1, 16'h1234, 16'hABCD, 5'd11);
    chk_bus("wr_a", 6'd1, 2'b01, 2'b11, 32'h0000_1234);
    chk("t1.job_ready", 32'(jr[0]), 32'd0);
    chk("t1.busy", 32'(bz[0]), 32'd1);
    tick(); chk_bus("wr_b", 6'd2, 2'b01, 2'b11, 32'h0000_ABCD);
    tick(); chk_bus("wr_shift", 6'd3, 2'b00, 2'b11, 32'h0000_000B);
    tick(); chk_bus("wr_ctrl", 6'd0, 2'b00, 2'b11, 32'h0000_0009);
    tick(); chk_bus("wait", 6'd0, 2'b11, 2'b11, 32'd0);
    repeat (19) tick();                   // T24: interrupt 20 cycles after WR_CTRL
    user_interrupt = 1'b1;
    tick(); user_interrupt = 1'b0;        // T25
    chk_bus("rd1.a", 6'd4, 2'b11, 2'b01, 32'd0);
    tick(); chk_bus("rd1.b", 6'd4, 2'b11, 2'b01, 32'd0);
    tick(); chk_bus("rd1.c", 6'd4, 2'b11, 2'b01, 32'd0);
    data_in = 32'h0000_0200; data_ready = 1'b1;
    tick(); data_ready = 1'b0; data_in = 32'hDEAD_BEEF;  // T28
    chk_bus("rd2.a", 6'd5, 2'b11, 2'b01, 32'd0);
    chk("rd2.res_out1", 32'(o1[0]), 32'h0200);
    tick(); chk("rd2.b.addr", 32'(ad[0]), 32'd5);
    tick(); chk("rd2.c.addr", 32'(ad[0]), 32'd5);
    data_in = 32'hABCD_0377; data_ready = 1'b1;
    tick(); data_ready = 1'b0; data_in = 32'd0;         // T31
    chk("done.res_valid", 32'(rv[0]), 32'd1);
    chk("done.res_out1", 32'(o1[0]), 32'h0200);
    chk("done.res_out2", 32'(o2[0]), 32'h0377);
    chk("done.res_timeout", 32'(rt[0]), 32'd0);
    chk("done.job_ready", 32'(jr[0]), 32'd0);
    chk_bus("done", 6'd0, 2'b11, 2'b11, 32'd0);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.res_valid", 32'(rv[0]), 32'd1);
      chk("bp.res_out1", 32'(o1[0]), 32'h0200);
      chk("bp.res_out2", 32'(o2[0]), 32'h0377);
      chk("bp.job_ready", 32'(jr[0]), 32'd0);
      chk("bp.wr_n", 32'(wn[0]), 32'h3);
      chk("bp.rd_n", 32'(rn[0]), 32'h3);
    end
    accept_result();
    chk("ack.res_valid", 32'(rv[0]), 32'd0);
    chk("ack.job_ready", 32'(jr[0]), 32'd1);
    chk("ack.busy", 32'(bz[0]), 32'd0);

    // Interrupt coinciding with counter==TIMEOUT_CYCLES on instance 1
    sel = 1'b1;
    start_job(2'd1, 1'b0, 16'h0100, 16'h0200, 5'd8);
    tick(); tick(); tick();               // T4
    chk_bus("tie.wr_ctrl", 6'd0, 2'b00, 2'b11, 32'h0000_0003);
    tick();                               // T5
    repeat (16) tick();                   // T21
    user_interrupt = 1'b1;
    tick(); user_interrupt = 1'b0;        // T22
    chk("tie.res_valid", 32'(rv[1]), 32'd0);
    chk_bus("tie.rd1", 6'd4, 2'b11, 2'b01, 32'd0);
    data_in = 32'h0000_1111; data_ready = 1'b1;
    tick();                               // T23
    chk_bus("tie.rd2", 6'd5, 2'b11, 2'b01, 32'd0);
    data_in = 32'h0000_2222;
    tick(); data_ready = 1'b0; data_in = 32'd0;  // T24
    chk("tie.res_valid2", 32'(rv[1]), 32'd1);
    chk("tie.res_timeout", 32'(rt[1]), 32'd0);
    chk("tie.res_out1", 32'(o1[1]), 32'h1111);
    chk("tie.res_out2", 32'(o2[1]), 32'h2222);
    accept_result();

    // Timeout, with an ignored interrupt during WR_B
    start_job(2'd2, 1'b1, 16'h0005, 16'h0006, 5'd3);
    tick();                               // T2, WR_B
    user_interrupt = 1'b1;
    tick(); user_interrupt = 1'b0;        // T3
    chk_bus("to.wr_shift", 6'd3, 2'b00, 2'b11, 32'h0000_0003);
    tick(); tick();                       // T5
    rd_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (rn[1] != 2'b11) rd_seen = 1'b1;
      tick();
    end                                   // T21
    if (rn[1] != 2'b11) rd_seen = 1'b1;
    chk("to.early_valid", 32'(rv[1]), 32'd0);
    tick();                               // T22
    chk("to.res_valid", 32'(rv[1]), 32'd1);
    chk("to.res_timeout", 32'(rt[1]), 32'd1);
    chk("to.res_out1", 32'(o1[1]), 32'd0);
    chk("to.res_out2", 32'(o2[1]), 32'd0);
    chk("to.no_reads", 32'(rd_seen), 32'd0);
    accept_result();

    // Asynchronous reset mid-cycle in RD_OUT1 on instance 0
    sel = 1'b0;
    start_job(2'd0, 1'b0, 16'h0001, 16'h0002, 5'd4);
    tick(); tick(); tick(); tick();       // T5
    user_interrupt = 1'b1;
    tick(); user_interrupt = 1'b0;        // T6
    chk("ar.pre.addr", 32'(ad[0]), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk_bus("ar", 6'd0, 2'b11, 2'b11, 32'd0);
    chk("ar.busy", 32'(bz[0]), 32'd0);
    chk("ar.job_ready", 32'(jr[0]), 32'd1);
    chk("ar.res_out1", 32'(o1[0]), 32'd0);
    chk("ar.res_out2", 32'(o2[0]), 32'd0);
    #2 rst = 1'b0;
    tick();

    // Next job after reset runs normally
    start_job(2'd0, 1'b1, 16'h0AAA, 16'h0BBB, 5'd14);
    chk_bus("post.wr_a", 6'd1, 2'b01, 2'b11, 32'h0000_0AAA);
    tick(); tick(); tick(); tick();       // T5
    user_interrupt = 1'b1;
    tick(); user_interrupt = 1'b0;        // T6
    data_in = 32'h0000_4444; data_ready = 1'b1;
    tick(); data_in = 32'h0000_5555;      // T7
    tick(); data_ready = 1'b0;            // T8
    chk("post.res_valid", 32'(rv[0]), 32'd1);
    chk("post.res_out1", 32'(o1[0]), 32'h4444);
    chk("post.res_out2", 32'(o2[0]), 32'h5555);
    accept_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
